iob_eth_rx_buf_ctrl: RTL and testbench
======================================

# iob_eth_rx_buf_ctrl

Double-buffer controller for the Ethernet receive path, in the RX_CLK domain between the nibble receiver and the dual-port RX frame memory. It steers each received frame's byte writes into one of two 2 KiB banks and acknowledges the receiver (`receive`) so it can accept the next frame. It tracks bank occupancy and frame lengths, exposes the oldest frame to the host-side reader, and drops frames when both banks are full.

## Interface
- `ADDR_W`, 11, byte-address width of one bank; the memory address is ADDR_W+1 bits.
- `DROP_W`, 8, width of the saturating dropped-frame counter.
- Decided: reset `rst`, synchronous, active-high; clock `RX_CLK`.
- `RX_CLK` in 1: receive clock, all logic on rising edge.
- `rst` in 1: synchronous active-high reset.
- `rx_wr` in 1: receiver byte-write strobe.
- `rx_addr` in ADDR_W: receiver byte address within the frame.
- `rx_data` in 8: receiver byte.
- `frameReceived` in 1: receiver holds high while a good frame awaits acknowledge.
- `receive` out 1: one-cycle acknowledge to the receiver.
- `buf_wr` out 1: frame-memory write enable.
- `buf_addr` out ADDR_W+1: `{bank, rx_addr}`.
- `buf_data` out 8: frame-memory write data.
- `rel` in 1: host pulse that releases the head frame.
- `frm_cnt` out 2: frames held (0..2).
- `head_bank` out 1: bank of the oldest held frame.
- `head_len` out ADDR_W+1: byte length of the head frame (0 when `frm_cnt`==0).
- `overrun` out 1: one-cycle pulse when a frame is dropped.
- `drop_cnt` out DROP_W: saturating count of dropped frames.

## Operation
- State: `wr_bank`, `rd_bank`, `full[1:0]`, `len0`/`len1` (ADDR_W+1), `byte_cnt` (ADDR_W+1, saturates at 2^ADDR_W), `drop` flag, FSM.
- FSM IDLE: wait for the first `rx_wr`. On that cycle, latch `drop = full[wr_bank]`, set `byte_cnt=1`, and go to RECV. If `frameReceived` arrives in IDLE with no bytes, go to ACK with `drop=1` (empty frame, nothing committed).
- FSM RECV: each `rx_wr` increments `byte_cnt`. When `frameReceived` is high, go to ACK.
- FSM ACK: drive `receive=1` for exactly this cycle.
  - If `~drop`: `full[wr_bank]<=1`, `len[wr_bank]<=byte_cnt`, toggle `wr_bank`.
  - If `drop` (non-empty frame): pulse `overrun`; `drop_cnt` +1, saturating at all-ones.
  - Clear `byte_cnt` and `drop`, then return to IDLE.
- Writes: `buf_wr = rx_wr & ~drop_eff`. `drop_eff` is the latched `drop`, or `full[wr_bank]` on the first-byte cycle. Data and address pass straight through, registered.
- Release: `rel` with `full[rd_bank]` clears `full[rd_bank]` and toggles `rd_bank`. `rel` with `frm_cnt`==0 is ignored.
- Simultaneous commit and release always target different banks; both take effect in the same cycle.
- A release during RECV does not un-drop the current frame; the drop decision is fixed at its first byte.
- `frm_cnt = full[0]+full[1]`; `head_bank = rd_bank`; `head_len = len[rd_bank]`, gated to 0 when the head bank is empty.

## Timing
- Reset values: FSM=IDLE, `wr_bank=rd_bank=0`, `full=0`, `len0=len1=0`, `byte_cnt=0`, and all outputs 0.
- `buf_wr`, `buf_addr` and `buf_data` are registered: 1-cycle latency from `rx_wr`/`rx_addr`/`rx_data`.
- `receive` is asserted the cycle after `frameReceived` is first sampled high in RECV, and lasts 1 cycle. The receiver leaves its CRC-check state on that cycle.
- Status outputs (`frm_cnt`, `head_len`, `head_bank`) update the cycle after the commit or release edge.
- Reset mid-frame: all state clears; any partial bank contents are discarded (the bank is not marked full).

## Structure
- Shared constants go in `iob_eth_defs.vh`: FSM encodings (`RXC_IDLE`, `RXC_RECV`, `RXC_ACK`), `RX_BANKS=2`, and default `ADDR_W`.
- Sub-module: `iob_eth_rx_bank_stat`, instanced ×2. It holds the `full` bit and length register, with set/clear/load ports.
- Top level holds the FSM, bank pointers and write steering.

## Test plan
- Single 64-byte frame: addr 0..63 → `buf_addr` 0x000..0x03F, `receive` 1 cycle after `frameReceived`, then `frm_cnt`=1, `head_bank`=0, `head_len`=64.
- Two back-to-back frames of 100 and 60 bytes: second frame written at 0x800..0x83B, `frm_cnt`=2. `rel` → `head_bank`=1, `head_len`=60, `frm_cnt`=1.
- Third frame with both banks full: `buf_wr` stays 0 throughout, `receive` is still pulsed, `overrun` pulses once, `drop_cnt`=1, `frm_cnt` stays 2.
- `rel` issued mid-frame while both banks are full: the current frame is still dropped, and the next frame is written to the freed bank.
- `rel` on the same cycle as ACK with one bank full: `frm_cnt` stays 1, and the head moves to the new frame's bank.
- Assert `rst` during RECV: next cycle all outputs are 0 and `frm_cnt`=0; the following frame lands in bank 0.

Source files
------------

// File: rtl/iob_eth_rx_buf_ctrl_pkg.sv
// Shared constants for the Ethernet RX double-buffer controller:
// FSM encoding, bank count and default bank address width.
package iob_eth_rx_buf_ctrl_pkg;

    typedef enum logic [1:0] {
        RXC_IDLE = 2'd0,
        RXC_RECV = 2'd1,
        RXC_ACK  = 2'd2
    } rxc_state_t;

    localparam int RX_BANKS   = 2;
    localparam int DEF_ADDR_W = 11;

endpackage

// File: rtl/iob_eth_rx_bank_stat.sv
// Per-bank status: occupancy flag plus the committed frame length.
// A set takes priority over a clear; the controller never issues both to one bank.
module iob_eth_rx_bank_stat
    import iob_eth_rx_buf_ctrl_pkg::*;
#(
    parameter int LEN_W = DEF_ADDR_W + 1
) (
    input  logic             RX_CLK,
    input  logic             rst,
    input  logic             set_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             full_o,
    output logic [LEN_W-1:0] len_o
);

    logic             full_q;
    logic [LEN_W-1:0] len_q;

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            full_q <= 1'b0;
            len_q  <= '0;
        end else begin
            if (set_i) begin
                full_q <= 1'b1;
            end else if (clr_i) begin
                full_q <= 1'b0;
            end
            if (load_i) begin
                len_q <= len_i;
            end
        end
    end

    assign full_o = full_q;
    assign len_o  = len_q;

endmodule

// File: rtl/iob_eth_rx_buf_ctrl.sv
// Ethernet RX double-buffer controller: steers receiver byte writes into one of
// two frame-memory banks, acknowledges each frame and exposes the oldest one.
//
// state    | meaning
// RXC_IDLE | waiting for the first byte of a frame (or an empty frameReceived)
// RXC_RECV | frame bytes arriving; drop decision already fixed
// RXC_ACK  | receive pulse; commit the frame or count it as dropped
module iob_eth_rx_buf_ctrl
    import iob_eth_rx_buf_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DROP_W = 8
) (
    input  logic              RX_CLK,
    input  logic              rst,
    input  logic              rx_wr_i,
    input  logic [ADDR_W-1:0] rx_addr_i,
    input  logic [7:0]        rx_data_i,
    input  logic              frameReceived_i,
    output logic              receive_o,
    output logic              buf_wr_o,
    output logic [ADDR_W:0]   buf_addr_o,
    output logic [7:0]        buf_data_o,
    input  logic              rel_i,
    output logic [1:0]        frm_cnt_o,
    output logic              head_bank_o,
    output logic [ADDR_W:0]   head_len_o,
    output logic              overrun_o,
    output logic [DROP_W-1:0] drop_cnt_o
);

    rxc_state_t          state_q;
    logic                wr_bank_q;
    logic                rd_bank_q;
    logic                drop_q;
    logic [ADDR_W:0]     byte_cnt_q;
    logic                buf_wr_q;
    logic [ADDR_W:0]     buf_addr_q;
    logic [7:0]          buf_data_q;
    logic                receive_q;
    logic                overrun_q;
    logic [DROP_W-1:0]   drop_cnt_q;

    logic [RX_BANKS-1:0] full;
    logic [ADDR_W:0]     len [RX_BANKS];
    logic [RX_BANKS-1:0] set_d;
    logic [RX_BANKS-1:0] clr_d;
    logic                drop_eff_d;
    logic                commit_d;
    logic                release_d;

    // On the first byte the latched flag is not yet valid, so look at the bank directly.
    always_comb begin
        drop_eff_d = (state_q == RXC_IDLE) ? full[wr_bank_q] : drop_q;
        commit_d   = (state_q == RXC_ACK) && !drop_q;
        release_d  = rel_i && full[rd_bank_q];
        set_d      = '0;
        clr_d      = '0;
        if (commit_d) begin
            set_d[wr_bank_q] = 1'b1;
        end
        if (release_d) begin
            clr_d[rd_bank_q] = 1'b1;
        end
    end

    for (genvar b = 0; b < RX_BANKS; b++) begin : g_bank
        iob_eth_rx_bank_stat #(
            .LEN_W (ADDR_W + 1)
        ) u_stat (
            .RX_CLK (RX_CLK),
            .rst    (rst),
            .set_i  (set_d[b]),
            .clr_i  (clr_d[b]),
            .load_i (set_d[b]),
            .len_i  (byte_cnt_q),
            .full_o (full[b]),
            .len_o  (len[b])
        );
    end

    always_ff @(posedge RX_CLK) begin
        if (rst) begin
            state_q    <= RXC_IDLE;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            drop_q     <= 1'b0;
            byte_cnt_q <= '0;
            buf_wr_q   <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
            receive_q  <= 1'b0;
            overrun_q  <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            buf_wr_q   <= rx_wr_i & ~drop_eff_d;
            buf_addr_q <= {wr_bank_q, rx_addr_i};
            buf_data_q <= rx_data_i;
            receive_q  <= 1'b0;
            overrun_q  <= 1'b0;
            if (release_d) begin
                rd_bank_q <= ~rd_bank_q;
            end
            case (state_q)
                RXC_IDLE: begin
                    if (rx_wr_i) begin
                        drop_q     <= full[wr_bank_q];
                        byte_cnt_q <= (ADDR_W + 1)'(1);
                        state_q    <= RXC_RECV;
                    end else if (frameReceived_i) begin
                        // Empty frame: acknowledged, nothing committed, not an overrun.
                        drop_q    <= 1'b1;
                        receive_q <= 1'b1;
                        state_q   <= RXC_ACK;
                    end
                end
                RXC_RECV: begin
                    if (rx_wr_i && !byte_cnt_q[ADDR_W]) begin
                        byte_cnt_q <= byte_cnt_q + (ADDR_W + 1)'(1);
                    end
                    if (frameReceived_i) begin
                        receive_q <= 1'b1;
                        state_q   <= RXC_ACK;
                        if (drop_q) begin
                            overrun_q <= 1'b1;
                            if (drop_cnt_q != '1) begin
                                drop_cnt_q <= drop_cnt_q + DROP_W'(1);
                            end
                        end
                    end
                end
                RXC_ACK: begin
                    if (!drop_q) begin
                        wr_bank_q <= ~wr_bank_q;
                    end
                    byte_cnt_q <= '0;
                    drop_q     <= 1'b0;
                    state_q    <= RXC_IDLE;
                end
                default: begin
                    state_q <= RXC_IDLE;
                end
            endcase
        end
    end

    assign receive_o   = receive_q;
    assign buf_wr_o    = buf_wr_q;
    assign buf_addr_o  = buf_addr_q;
    assign buf_data_o  = buf_data_q;
    assign overrun_o   = overrun_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign frm_cnt_o   = {1'b0, full[0]} + {1'b0, full[1]};
    assign head_bank_o = rd_bank_q;
    assign head_len_o  = full[rd_bank_q] ? len[rd_bank_q] : '0;

endmodule

// File: tb/tb_iob_eth_rx_buf_ctrl.sv
// Directed bench for the RX double-buffer controller: inputs change on the
// falling edge, outputs are compared on the falling edge after each rising edge.
module tb_iob_eth_rx_buf_ctrl;

    logic        RX_CLK = 1'b0;
    logic        rst;
    logic        rx_wr;
    logic [10:0] rx_addr;
    logic [7:0]  rx_data;
    logic        frameReceived;
    logic        receive;
    logic        buf_wr;
    logic [11:0] buf_addr;
    logic [7:0]  buf_data;
    logic        rel;
    logic [1:0]  frm_cnt;
    logic        head_bank;
    logic [11:0] head_len;
    logic        overrun;
    logic [7:0]  drop_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 RX_CLK = ~RX_CLK;

    iob_eth_rx_buf_ctrl #(
        .ADDR_W (11),
        .DROP_W (8)
    ) dut (
        .RX_CLK          (RX_CLK),
        .rst             (rst),
        .rx_wr_i         (rx_wr),
        .rx_addr_i       (rx_addr),
        .rx_data_i       (rx_data),
        .frameReceived_i (frameReceived),
        .receive_o       (receive),
        .buf_wr_o        (buf_wr),
        .buf_addr_o      (buf_addr),
        .buf_data_o      (buf_data),
        .rel_i           (rel),
        .frm_cnt_o       (frm_cnt),
        .head_bank_o     (head_bank),
        .head_len_o      (head_len),
        .overrun_o       (overrun),
        .drop_cnt_o      (drop_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [1:0] cnt, input logic bank,
                                input logic [11:0] len, input logic [7:0] dcnt);
        check({tag, ".frm_cnt"}, 32'(frm_cnt), 32'(cnt));
        check({tag, ".head_bank"}, 32'(head_bank), 32'(bank));
        check({tag, ".head_len"}, 32'(head_len), 32'(len));
        check({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(dcnt));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".receive"}, 32'(receive), 32'd0);
        check({tag, ".buf_wr"}, 32'(buf_wr), 32'd0);
        check({tag, ".buf_addr"}, 32'(buf_addr), 32'd0);
        check({tag, ".buf_data"}, 32'(buf_data), 32'd0);
        check({tag, ".overrun"}, 32'(overrun), 32'd0);
        check_status(tag, 2'd0, 1'b0, 12'd0, 8'd0);
    endtask

    task automatic chk_byte(input int i, input logic bank, input logic wr);
        logic [11:0] a;
        logic [7:0]  d;
        a = {bank, i[10:0]};
        d = i[7:0] ^ 8'hA5;
        check("byte.buf_wr", 32'(buf_wr), 32'(wr));
        if (wr) begin
            check("byte.buf_addr", 32'(buf_addr), 32'(a));
            check("byte.buf_data", 32'(buf_data), 32'(d));
        end
    endtask

    // One frame of n bytes, then frameReceived held until the acknowledge.
    task automatic send_frame(input int n, input logic bank, input logic wr, input logic ovr,
                              input logic rel_mid, input logic rel_ack);
        for (int i = 0; i < n; i++) begin
            @(negedge RX_CLK);
            if (i > 0) chk_byte(i - 1, bank, wr);
            rx_wr   = 1'b1;
            rx_addr = i[10:0];
            rx_data = i[7:0] ^ 8'hA5;
            rel     = rel_mid && (i == n / 2);
        end
        @(negedge RX_CLK);
        chk_byte(n - 1, bank, wr);
        check("ack.before", 32'(receive), 32'd0);
        rx_wr         = 1'b0;
        rel           = 1'b0;
        frameReceived = 1'b1;
        @(negedge RX_CLK);
        check("ack.receive", 32'(receive), 32'd1);
        check("ack.overrun", 32'(overrun), 32'(ovr));
        check("ack.buf_wr_idle", 32'(buf_wr), 32'd0);
        frameReceived = 1'b0;
        rel           = rel_ack;
        @(negedge RX_CLK);
        check("ack.after", 32'(receive), 32'd0);
        check("ack.overrun_after", 32'(overrun), 32'd0);
        rel = 1'b0;
    endtask

    task automatic pulse_rel();
        @(negedge RX_CLK);
        rel = 1'b1;
        @(negedge RX_CLK);
        rel = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        rx_wr         = 1'b0;
        rx_addr       = '0;
        rx_data       = '0;
        frameReceived = 1'b0;
        rel           = 1'b0;
        repeat (2) @(negedge RX_CLK);
        check_all_zero("reset");
        rst = 1'b0;

        // Single 64-byte frame into bank 0
        send_frame(64, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_status("f64", 2'd1, 1'b0, 12'd64, 8'd0);

        @(negedge RX_CLK);
        rst = 1'b1;
        @(negedge RX_CLK);
        check_status("rst_idle", 2'd0, 1'b0, 12'd0, 8'd0);
        rst = 1'b0;

        // Back-to-back 100 and 60 byte frames
        send_frame(100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_status("f100", 2'd1, 1'b0, 12'd100, 8'd0);
        send_frame(60, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_status("f60", 2'd2, 1'b0, 12'd100, 8'd0);

        // Both banks full: dropped frame
        send_frame(30, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check_status("drop1", 2'd2, 1'b0, 12'd100, 8'd1);

        pulse_rel();
        check_status("rel1", 2'd1, 1'b1, 12'd60, 8'd1);

        // Refill bank 0, then release mid-frame while both are full
        send_frame(20, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_status("f20", 2'd2, 1'b1, 12'd60, 8'd1);
        send_frame(40, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check_status("drop_mid_rel", 2'd1, 1'b0, 12'd20, 8'd2);
        send_frame(50, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check_status("f50", 2'd2, 1'b0, 12'd20, 8'd2);

        // Release coincident with commit
        pulse_rel();
        check_status("rel2", 2'd1, 1'b1, 12'd50, 8'd2);
        send_frame(16, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        check_status("rel_at_ack", 2'd1, 1'b0, 12'd16, 8'd2);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) begin
            @(negedge RX_CLK);
            rx_wr   = 1'b1;
            rx_addr = i[10:0];
            rx_data = i[7:0] ^ 8'hA5;
        end
        @(negedge RX_CLK);
        rx_wr = 1'b0;
        rst   = 1'b1;
        @(negedge RX_CLK);
        check_all_zero("rst_recv");
        rst = 1'b0;

        // Release with nothing held is ignored
        pulse_rel();
        check_status("rel_empty", 2'd0, 1'b0, 12'd0, 8'd0);

        send_frame(8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_status("f8", 2'd1, 1'b0, 12'd8, 8'd0);

        // Empty frame: acknowledged without commit or overrun
        @(negedge RX_CLK);
        frameReceived = 1'b1;
        @(negedge RX_CLK);
        check("empty.receive", 32'(receive), 32'd1);
        check("empty.overrun", 32'(overrun), 32'd0);
        frameReceived = 1'b0;
        @(negedge RX_CLK);
        check("empty.after", 32'(receive), 32'd0);
        check_status("empty", 2'd1, 1'b0, 12'd8, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
